// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: byte-request handshake and frame status between a client and the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic tx_busy;
  logic tx_done;
  logic tx_error;
  modport master(output tx_data, tx_valid, input tx_ready, tx_busy, tx_done, tx_error);
  modport slave(input tx_data, tx_valid, output tx_ready, tx_busy, tx_done, tx_error);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-drain pull-low enables.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         CLK100MHZ,
  input  logic         CPU_RESETN,
  ps2_host_tx_if.slave tx,
  input  logic         PS2_CLK_IN,
  input  logic         PS2_DATA_IN,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);
  localparam int CW = $clog2(INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  // decided two cycles early so the tx_error pulse, after ERR and the IDLE entry, lands TIMEOUT_CYCLES after RELEASE
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 3);
  typedef enum logic [2:0] {IDLE, INHIBIT, RELEASE, SHIFT, ACK, WAIT_IDLE, ERR} state_t;
  state_t state, state_n;
  logic [1:0] clk_sync, data_sync;
  logic clk_prev, fall, timeout;
  logic [7:0] byte_r, byte_n;
  logic par_r, par_n, data_r, data_n, done_r, done_n, err_r, err_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  assign fall = clk_prev & ~clk_sync[1];
  assign timeout = cnt == TO_LAST;
  assign ps2_clk_oe = state == INHIBIT;
  assign ps2_data_oe = data_r & (state inside {RELEASE, SHIFT});
  assign tx.tx_ready = state == IDLE;
  assign tx.tx_busy = state != IDLE;
  assign tx.tx_done = done_r;
  assign tx.tx_error = err_r;
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) begin
      clk_sync <= 2'b11;
      data_sync <= 2'b11;
      clk_prev <= 1'b1;
      state <= IDLE;
      byte_r <= '0;
      par_r <= 1'b0;
      data_r <= 1'b0;
      done_r <= 1'b0;
      err_r <= 1'b0;
      cnt <= '0;
      idx <= '0;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK_IN};
      data_sync <= {data_sync[0], PS2_DATA_IN};
      clk_prev <= clk_sync[1];
      state <= state_n;
      byte_r <= byte_n;
      par_r <= par_n;
      data_r <= data_n;
      done_r <= done_n;
      err_r <= err_n;
      cnt <= cnt_n;
      idx <= idx_n;
    end
  always_comb begin
    state_n = state;
    byte_n = byte_r;
    par_n = par_r;
    data_n = data_r;
    done_n = 1'b0;
    err_n = 1'b0;
    cnt_n = cnt;
    idx_n = idx;
    case (state)
      IDLE: if (tx.tx_valid) begin
        state_n = INHIBIT;
        byte_n = tx.tx_data;
        par_n = ~^tx.tx_data;
        cnt_n = '0;
      end
      INHIBIT: begin
        cnt_n = cnt + CW'(1);
        if (cnt == INH_LAST) begin
          state_n = RELEASE;
          data_n = 1'b1;
        end
      end
      RELEASE: begin
        state_n = SHIFT;
        cnt_n = '0;
        idx_n = '0;
      end
      SHIFT, ACK, WAIT_IDLE: begin
        cnt_n = cnt + CW'(1);
        if (timeout) begin
          state_n = ERR;
          data_n = 1'b0;
        end else if (state == SHIFT) begin
          if (fall) begin
            data_n = idx < 4'd8 ? ~byte_r[idx[2:0]] : idx == 4'd8 ? ~par_r : 1'b0;
            idx_n = idx + 4'd1;
            state_n = idx == 4'd9 ? ACK : SHIFT;
          end
        end else if (state == ACK) begin
          if (fall) state_n = data_sync[1] ? ERR : WAIT_IDLE;
        end else if (clk_sync[1] && data_sync[1]) begin
          state_n = IDLE;
          done_n = 1'b1;
        end
      end
      ERR: begin
        state_n = IDLE;
        data_n = 1'b0;
        err_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: device-model bench; expected outcomes are queued at request time and checked on each done/error pulse.
module tb_ps2_host_tx;
  localparam int INH = 40;
  localparam int TO = 600;
  localparam int H = 8;
  typedef struct {
    bit err;
    logic [10:0] frame;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic ps2_clk_oe, ps2_data_oe, ps2_clk, ps2_data;
  logic [10:0] cap;
  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int inh_run = 0;
  int inh_len = 0;
  ps2_host_tx_if tx_if();
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .CLK100MHZ(clk),
    .CPU_RESETN(rst_n),
    .tx(tx_if),
    .PS2_CLK_IN(ps2_clk),
    .PS2_DATA_IN(ps2_data),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );
  assign ps2_clk = ~ps2_clk_oe & dev_clk;
  assign ps2_data = ~ps2_data_oe & dev_data;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    tick(1);
    tx_if.tx_data = b;
    tx_if.tx_valid = 1'b1;
    tick(1);
    tx_if.tx_valid = 1'b0;
  endtask
  task automatic wait_release(output bit ok);
    for (int n = 0; n < 100 && !ps2_clk_oe; n++) @(negedge clk);
    chk("inhibit_start", ps2_clk_oe, 1);
    for (int n = 0; n < INH + 20 && ps2_clk_oe; n++) @(negedge clk);
    chk("inhibit_end", ps2_clk_oe, 0);
    ok = !ps2_clk_oe;
  endtask
  task automatic dev_frame(input bit ack);
    bit ok;
    wait_release(ok);
    if (!ok) return;
    tick(H);
    cap[0] = ps2_data;
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      tick(H);
      dev_clk = 1'b1;
      cap[i] = ps2_data;
      tick(H);
    end
    if (ack) dev_data = 1'b0;
    tick(2);
    dev_clk = 1'b0;
    tick(H);
    dev_clk = 1'b1;
    tick(H / 2);
    dev_data = 1'b1;
    tick(H);
  endtask
  always @(negedge clk) begin
    if (ps2_clk_oe) inh_run = inh_run + 1;
    else if (inh_run != 0) begin
      inh_len = inh_run;
      inh_run = 0;
    end
  end
  always @(negedge clk)
    if (tx_if.tx_done || tx_if.tx_error) begin
      if (exp_q.size() == 0) chk("unexpected_pulse", {tx_if.tx_done, tx_if.tx_error}, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("outcome_done_err", {tx_if.tx_done, tx_if.tx_error}, mon_e.err ? 1 : 2);
        chk("ready_with_pulse", tx_if.tx_ready, 1);
        chk("inhibit_len", inh_len, INH);
        if (!mon_e.err) chk("frame", cap, mon_e.frame);
      end
    end
  initial begin
    bit ok;
    int k;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data = 8'h00;
    tick(3);
    chk("rst_ready", tx_if.tx_ready, 1);
    chk("rst_busy", tx_if.tx_busy, 0);
    chk("rst_done", tx_if.tx_done, 0);
    chk("rst_error", tx_if.tx_error, 0);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    rst_n = 1'b1;
    tick(2);
    exp_q.push_back('{0, 11'b11_1110_1101_0});
    send(8'hED);
    dev_frame(1);
    exp_q.push_back('{0, 11'b10_0000_0111_0});
    send(8'h07);
    dev_frame(1);
    exp_q.push_back('{0, 11'b11_0000_0000_0});
    send(8'h00);
    dev_frame(1);
    // device never clocks: error must land exactly TO cycles after the RELEASE cycle
    exp_q.push_back('{1, 11'h0});
    send(8'h3C);
    wait_release(ok);
    k = 0;
    while (!tx_if.tx_error && k < TO + 50) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_latency", k, TO);
    chk("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    tick(3);
    exp_q.push_back('{1, 11'h0});
    send(8'h5A);
    dev_frame(0);
    send(8'hFF);
    wait_release(ok);
    tick(H);
    for (int i = 1; i <= 4; i++) begin
      dev_clk = 1'b0;
      tick(H);
      if (i < 4) begin
        dev_clk = 1'b1;
        tick(H);
      end
    end
    chk("mid_busy", tx_if.tx_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("mid_rst_ready", tx_if.tx_ready, 1);
    dev_clk = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(4);
    exp_q.push_back('{0, 11'b10_1111_0100_0});
    send(8'hF4);
    dev_frame(1);
    send(8'h00);
    tick(10);
    chk("inh_clk_oe", ps2_clk_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("inh_rst_clk_oe", ps2_clk_oe, 0);
    tick(3);
    rst_n = 1'b1;
    tick(4);
    exp_q.push_back('{0, 11'b11_1010_1010_0});
    exp_q.push_back('{0, 11'b11_0101_0101_0});
    tick(1);
    tx_if.tx_data = 8'hAA;
    tx_if.tx_valid = 1'b1;
    tick(1);
    tx_if.tx_data = 8'h55;
    fork
      dev_frame(1);
      begin
        int drops, n;
        drops = 0;
        n = 0;
        while (!tx_if.tx_done && n < 2000) begin
          @(negedge clk);
          if (!tx_if.tx_done && !tx_if.tx_busy) drops++;
          n++;
        end
        chk("busy_held", drops, 0);
        chk("b2b_done_seen", tx_if.tx_done, 1);
        @(negedge clk);
        chk("b2b_accept_busy", {tx_if.tx_busy, tx_if.tx_ready}, 2);
      end
    join
    tx_if.tx_valid = 1'b0;
    dev_frame(1);
    tick(20);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end
endmodule
